bldc_pwm_comm: RTL and testbench

//  Six-gate PWM/commutation generator for the BLDC controller. Consumes the register-block

---
 rtl/bldc_pkg.sv | 45 ++++
 rtl/bldc_pwm_comm_if.sv | 29 ++
 rtl/bldc_deadtime.sv | 55 +++++
 rtl/bldc_pwm_comm.sv | 89 ++++++++
 tb/tb_bldc_pwm_comm.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/bldc_pkg.sv
// Shared constants, commutation step encoding and gate-request decode for the
// BLDC PWM/commutation generator.
package bldc_pkg;

  localparam int CNT_W_DEF  = 12;
  localparam int DT_CYC_DEF = 8;

  typedef enum logic [2:0] {
    COMM_0     = 3'd0,
    COMM_1     = 3'd1,
    COMM_2     = 3'd2,
    COMM_3     = 3'd3,
    COMM_4     = 3'd4,
    COMM_5     = 3'd5,
    COMM_COAST = 3'd6
  } comm_e;

  typedef struct packed {
    logic ah;
    logic al;
    logic bh;
    logic bl;
    logic ch;
    logic cl;
  } gate_req_t;

  // High side carries the chopped PWM; the low side stays on for the whole step.
  function automatic gate_req_t comm_decode(input logic [2:0] comm,
                                            input logic       pwm,
                                            input logic       en);
    gate_req_t r;
    r = '0;
    case (comm_e'(comm))
      COMM_0:  begin r.ah = pwm; r.bl = en; end
      COMM_1:  begin r.ah = pwm; r.cl = en; end
      COMM_2:  begin r.bh = pwm; r.cl = en; end
      COMM_3:  begin r.bh = pwm; r.al = en; end
      COMM_4:  begin r.ch = pwm; r.al = en; end
      COMM_5:  begin r.ch = pwm; r.bl = en; end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bldc_pwm_comm_if.sv
// Register-block to gate-driver bundle for the PWM/commutation generator.
interface bldc_pwm_comm_if #(
  parameter int CNT_W = bldc_pkg::CNT_W_DEF
);
  logic             pwm_en_i;
  logic             adc_en_i;
  logic [CNT_W-1:0] pwm_period_i;
  logic [CNT_W-1:0] pwm_duty_i;
  logic [2:0]       comm_i;

  logic             ah_o;
  logic             al_o;
  logic             bh_o;
  logic             bl_o;
  logic             ch_o;
  logic             cl_o;
  logic             adc_trig_o;
  logic             pwm_cycle_o;

  modport master (
    output pwm_en_i, adc_en_i, pwm_period_i, pwm_duty_i, comm_i,
    input  ah_o, al_o, bh_o, bl_o, ch_o, cl_o, adc_trig_o, pwm_cycle_o
  );

  modport slave (
    input  pwm_en_i, adc_en_i, pwm_period_i, pwm_duty_i, comm_i,
    output ah_o, al_o, bh_o, bl_o, ch_o, cl_o, adc_trig_o, pwm_cycle_o
  );
endinterface

// File: rtl/bldc_deadtime.sv
// Per-phase dead-time insertion and shoot-through interlock between the high
// and low gate of one half-bridge.
module bldc_deadtime
  import bldc_pkg::*;
#(
  parameter int DT_CYC = DT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hi_req,
  input  logic lo_req,
  output logic hi_o,
  output logic lo_o
);

  localparam int              DT_W   = $clog2(DT_CYC + 2);
  localparam logic [DT_W-1:0] DT_MAX = DT_W'(DT_CYC);

  logic [DT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [DT_W-1:0] lo_cnt_q, lo_cnt_d;
  logic            hi_q, hi_d;
  logic            lo_q, lo_d;
  logic            hi_run, lo_run;

  // A gate may only time its dead gap while the partner gate is already off;
  // conflicting requests leave both gates off.
  always_comb begin
    hi_run   = hi_req && !lo_req && !lo_q;
    lo_run   = lo_req && !hi_req && !hi_q;
    hi_cnt_d = '0;
    lo_cnt_d = '0;
    if (hi_run) hi_cnt_d = (hi_cnt_q == DT_MAX) ? hi_cnt_q : hi_cnt_q + DT_W'(1);
    if (lo_run) lo_cnt_d = (lo_cnt_q == DT_MAX) ? lo_cnt_q : lo_cnt_q + DT_W'(1);
    hi_d     = hi_run && (hi_cnt_q == DT_MAX);
    lo_d     = lo_run && (lo_cnt_q == DT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/bldc_pwm_comm.sv
// Six-gate BLDC PWM/commutation generator: period counter with shadowed
// settings, commutation decode, per-phase dead-time and ADC/cycle pulses.
module bldc_pwm_comm
  import bldc_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DT_CYC = DT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  bldc_pwm_comm_if.slave   bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_sh_q, per_sh_d;
  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [2:0]       comm_sh_q, comm_sh_d;
  logic             cyc_q, cyc_d;
  logic             trig_q, trig_d;
  logic             wrap;
  logic             load;
  logic             pwm;
  gate_req_t        req;

  // Settings are sampled only while idle or at the period boundary, so a
  // mid-period register write never distorts the running period.
  always_comb begin
    wrap      = bus.pwm_en_i && (cnt_q == per_sh_q);
    load      = !bus.pwm_en_i || wrap;
    cnt_d     = load ? '0 : cnt_q + CNT_W'(1);
    per_sh_d  = load ? bus.pwm_period_i : per_sh_q;
    duty_sh_d = load ? bus.pwm_duty_i   : duty_sh_q;
    comm_sh_d = load ? bus.comm_i       : comm_sh_q;
    pwm       = bus.pwm_en_i && (cnt_q < duty_sh_q);
    req       = comm_decode(comm_sh_q, pwm, bus.pwm_en_i);
    cyc_d     = wrap;
    trig_d    = bus.pwm_en_i && bus.adc_en_i && (duty_sh_q != '0)
                && (cnt_q == (duty_sh_q >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      per_sh_q  <= '0;
      duty_sh_q <= '0;
      comm_sh_q <= '0;
      cyc_q     <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      comm_sh_q <= comm_sh_d;
      cyc_q     <= cyc_d;
      trig_q    <= trig_d;
    end
  end

  bldc_deadtime #(.DT_CYC(DT_CYC)) u_dt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .hi_req (req.ah),
    .lo_req (req.al),
    .hi_o   (bus.ah_o),
    .lo_o   (bus.al_o)
  );

  bldc_deadtime #(.DT_CYC(DT_CYC)) u_dt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .hi_req (req.bh),
    .lo_req (req.bl),
    .hi_o   (bus.bh_o),
    .lo_o   (bus.bl_o)
  );

  bldc_deadtime #(.DT_CYC(DT_CYC)) u_dt_c (
    .clk    (clk),
    .rst_n  (rst_n),
    .hi_req (req.ch),
    .lo_req (req.cl),
    .hi_o   (bus.ch_o),
    .lo_o   (bus.cl_o)
  );

  assign bus.adc_trig_o  = trig_q;
  assign bus.pwm_cycle_o = cyc_q;

endmodule

// File: tb/tb_bldc_pwm_comm.sv
// Directed bench for bldc_pwm_comm: period 10, dead-time 2, gate patterns
// compared cycle by cycle against hand-derived windows.
module tb_bldc_pwm_comm;
  import bldc_pkg::*;

  localparam int CNT_W  = 12;
  localparam int DT_CYC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bldc_pwm_comm_if #(.CNT_W(CNT_W)) bus ();

  bldc_pwm_comm #(.CNT_W(CNT_W), .DT_CYC(DT_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;

  // {ah, al, bh, bl, ch, cl, adc_trig, pwm_cycle}
  logic [7:0] obs_v;
  assign obs_v = {bus.ah_o, bus.al_o, bus.bh_o, bus.bl_o,
                  bus.ch_o, bus.cl_o, bus.adc_trig_o, bus.pwm_cycle_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=0x%0h want=0x%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [7:0] mk(input bit ah, input bit al, input bit bh, input bit bl,
                                    input bit ch, input bit cl, input bit trig, input bit cyc);
    return {ah, al, bh, bl, ch, cl, trig, cyc};
  endfunction

  function automatic bit inr(input int kk, input int lo, input int hi);
    return ((kk % 10) >= lo) && ((kk % 10) <= hi);
  endfunction

  function automatic bit wrp(input int kk);
    return (kk > 0) && ((kk % 10) == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  always @(negedge clk)
    chk("interlock", 32'({obs_v[7] & obs_v[6], obs_v[5] & obs_v[4], obs_v[3] & obs_v[2]}), 32'd0);

  initial begin
    bus.pwm_en_i     = 1'b0;
    bus.adc_en_i     = 1'b0;
    bus.pwm_period_i = 12'd9;
    bus.pwm_duty_i   = 12'd5;
    bus.comm_i       = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'(obs_v), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle", 32'(obs_v), 32'd0);

    // Basic chopping on AH with BL held, dead-time 2
    bus.pwm_en_i = 1'b1;
    k = 0;
    while (k < 34) begin
      chk("t1_basic", 32'(obs_v), 32'(mk(k >= 3 && inr(k, 3, 5), 0, 0, k >= 3, 0, 0, 0, wrp(k))));
      tick();
    end

    // Duty write mid-period only affects the following period
    bus.pwm_duty_i = 12'd8;
    while (k < 50) begin
      chk("t2_shadow", 32'(obs_v),
          32'(mk((k < 40) ? inr(k, 3, 5) : inr(k, 3, 8), 0, 0, 1, 0, 0, 0, wrp(k))));
      tick();
    end

    // 100% duty, then step 0->3 at wrap: AH off, AL on after the dead gap
    bus.pwm_duty_i = 12'd10;
    while (k < 80) begin
      chk("t3_comm", 32'(obs_v),
          32'(mk((k >= 53 && k <= 58) || (k >= 63 && k <= 70), k >= 74, k >= 74, k <= 70,
                 0, 0, 0, wrp(k))));
      if (k == 60) bus.comm_i = 3'd3;
      tick();
    end

    // ADC trigger at cnt 5 with duty 10; duty 0 silences high side; coast
    bus.pwm_duty_i = 12'd0;
    bus.adc_en_i   = 1'b1;
    while (k < 110) begin
      chk("t4_coast", 32'(obs_v),
          32'(mk(0, k <= 100, k <= 90, 0, 0, 0, k == 86, wrp(k))));
      if (k == 90) bus.comm_i = 3'd6;
      tick();
    end

    // Duty 6 ADC trigger at cnt 3, then adc_en dropped
    bus.pwm_duty_i = 12'd6;
    bus.comm_i     = 3'd0;
    while (k < 154) begin
      chk("t5_adc", 32'(obs_v),
          32'(mk(k >= 123 && inr(k, 3, 6), 0, 0, k >= 123, 0, 0, k == 124 || k == 134, wrp(k))));
      if (k == 135) bus.adc_en_i = 1'b0;
      if (k == 153) bus.pwm_en_i = 1'b0;
      tick();
    end

    // Enable dropped mid-period: everything off, then clean restart
    while (k < 157) begin
      chk("t6_disable", 32'(obs_v), 32'd0);
      tick();
    end
    bus.pwm_en_i = 1'b1;
    k = 0;
    while (k < 14) begin
      chk("t6_reenable", 32'(obs_v),
          32'(mk(k >= 3 && inr(k, 3, 6), 0, 0, k >= 3, 0, 0, 0, wrp(k))));
      if (k < 13) tick();
      else break;
    end

    // Asynchronous reset while AH and BL are on
    rst_n = 1'b0;
    bus.pwm_en_i = 1'b0;
    #1;
    chk("rst_async", 32'(obs_v), 32'd0);
    tick();
    chk("rst_hold", 32'(obs_v), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_release", 32'(obs_v), 32'd0);
    bus.pwm_en_i = 1'b1;
    k = 0;
    while (k < 13) begin
      chk("t6_after_rst", 32'(obs_v),
          32'(mk(k >= 3 && inr(k, 3, 6), 0, 0, k >= 3, 0, 0, 0, wrp(k))));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
